// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN sequencing types: sequencer state encoding, default message
// width and the substate index map used to wire wrappers onto the sequencer.
package mbtrain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_RUN,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } mbtrain_state_e;

    localparam int unsigned MBTRAIN_MSG_W = 4;

    // Service order of the MBTRAIN substate wrappers
    localparam int unsigned SELFCAL_IDX         = 0;
    localparam int unsigned VALVREF_IDX         = 1;
    localparam int unsigned DATAVREF_IDX        = 2;
    localparam int unsigned SPEEDIDLE_IDX       = 3;
    localparam int unsigned CLKCAL_IDX          = 4;
    localparam int unsigned VALTRAINCENTER_IDX  = 5;
    localparam int unsigned DATATRAINCENTER_IDX = 6;
    localparam int unsigned LINKSPEED_IDX       = 7;

endpackage

// File: rtl/mbtrain_msg_mux.sv
// Registered indexed select of one wrapper's sideband message/valid; the
// output registers read zero whenever the selection is not active.
module mbtrain_msg_mux
    import mbtrain_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned MSG_W = MBTRAIN_MSG_W,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic [IDX_W-1:0]   idx,
    input  logic [N-1:0]       valid_vec,
    input  logic [N*MSG_W-1:0] msg_vec,
    output logic [MSG_W-1:0]   msg_out,
    output logic               valid_out
);

    logic sel_valid;

    always_comb begin
        sel_valid = valid_vec[idx];
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            valid_out <= 1'b0;
            msg_out   <= '0;
        end else begin
            valid_out <= sel_valid;
            // Message is zeroed unless the selected wrapper flags it valid
            msg_out   <= sel_valid ? msg_vec[idx*MSG_W +: MSG_W] : '0;
        end
    end

endmodule

// File: rtl/mbtrain_substate_sequencer.sv
// Walks the MBTRAIN substate wrappers one at a time in index order and muxes
// the active wrapper's sideband traffic. Optional timeout: MBTRAIN_SEQ_TIMEOUT_EN.
module mbtrain_substate_sequencer
    import mbtrain_pkg::*;
#(
    parameter int unsigned NUM_SUBSTATES  = 8,
    parameter int unsigned MSG_W          = MBTRAIN_MSG_W,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_en,
    input  logic [NUM_SUBSTATES-1:0]         i_skip_mask,
    input  logic [NUM_SUBSTATES-1:0]         i_substate_ack,
    input  logic [NUM_SUBSTATES-1:0]         i_substate_valid,
    input  logic [NUM_SUBSTATES*MSG_W-1:0]   i_substate_msg,
    output logic [NUM_SUBSTATES-1:0]         o_substate_en,
    output logic [MSG_W-1:0]                 o_sideband_message,
    output logic                             o_valid,
    output logic [$clog2(NUM_SUBSTATES)-1:0] o_current_idx,
    output logic                             o_done,
    output logic                             o_timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_SUBSTATES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SUBSTATES - 1);

    if (NUM_SUBSTATES < 2 || NUM_SUBSTATES > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("mbtrain_substate_sequencer: parameter out of range");
    end

    mbtrain_state_e             state;
    logic [IDX_W-1:0]           idx;
    logic [NUM_SUBSTATES-1:0]   en_q;
    logic                       done_q;
    logic                       mux_active;

`ifdef MBTRAIN_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_err;
`endif

    // Dropping i_en clears everything exactly like reset does
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            state  <= ST_IDLE;
            idx    <= '0;
            en_q   <= '0;
            done_q <= 1'b0;
`ifdef MBTRAIN_SEQ_TIMEOUT_EN
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_SELECT;
                    idx   <= '0;
                end
                ST_SELECT: begin
                    if (i_skip_mask[idx]) begin
                        if (idx == LAST_IDX) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        en_q  <= NUM_SUBSTATES'(1) << idx;
                        state <= ST_RUN;
`ifdef MBTRAIN_SEQ_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (i_substate_ack[idx]) begin
                        en_q  <= '0;
                        state <= ST_GAP;
                    end
`ifdef MBTRAIN_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        en_q    <= '0;
                        tmo_err <= 1'b1;
                        state   <= ST_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    // One all-idle cycle lets the wrapper drop back to its own idle
                    if (idx == LAST_IDX) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_SELECT;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mux_active = (state == ST_RUN) && i_en;
    end

    mbtrain_msg_mux #(
        .N     (NUM_SUBSTATES),
        .MSG_W (MSG_W),
        .IDX_W (IDX_W)
    ) u_msg_mux (
        .clk       (clk),
        .rst       (rst),
        .active    (mux_active),
        .idx       (idx),
        .valid_vec (i_substate_valid),
        .msg_vec   (i_substate_msg),
        .msg_out   (o_sideband_message),
        .valid_out (o_valid)
    );

    assign o_substate_en = en_q;
    assign o_current_idx = idx;
    assign o_done        = done_q;

`ifdef MBTRAIN_SEQ_TIMEOUT_EN
    assign o_timeout_err = tmo_err;
`else
    assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mbtrain_substate_sequencer.sv
// Scoreboard bench for mbtrain_substate_sequencer with 4 substates; timeout
// scenarios are exercised when MBTRAIN_SEQ_TIMEOUT_EN is defined.
module tb_mbtrain_substate_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [3:0]  i_skip_mask;
    logic [3:0]  i_substate_ack;
    logic [3:0]  i_substate_valid;
    logic [15:0] i_substate_msg;
    logic [3:0]  o_substate_en;
    logic [3:0]  o_sideband_message;
    logic        o_valid;
    logic [1:0]  o_current_idx;
    logic        o_done;
    logic        o_timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          cyc;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];

    mbtrain_substate_sequencer #(
        .NUM_SUBSTATES  (4),
        .MSG_W          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_en               (i_en),
        .i_skip_mask        (i_skip_mask),
        .i_substate_ack     (i_substate_ack),
        .i_substate_valid   (i_substate_valid),
        .i_substate_msg     (i_substate_msg),
        .o_substate_en      (o_substate_en),
        .o_sideband_message (o_sideband_message),
        .o_valid            (o_valid),
        .o_current_idx      (o_current_idx),
        .o_done             (o_done),
        .o_timeout_err      (o_timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic r, input logic [3:0] ack,
                         input logic [3:0] vld, input logic [15:0] msg);
        i_en             = en;
        rst              = r;
        i_substate_ack   = ack;
        i_substate_valid = vld;
        i_substate_msg   = msg;
    endtask

    function automatic logic [12:0] obs();
        return {o_substate_en, o_current_idx, o_done, o_timeout_err, o_valid, o_sideband_message};
    endfunction

    function automatic logic [12:0] ev(input logic [3:0] en, input logic [1:0] idx, input logic done,
                                       input logic err, input logic vld, input logic [3:0] msg);
        return {en, idx, done, err, vld, msg};
    endfunction

    task automatic test_reset();
        exp_t ex;
        i_skip_mask = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 4'b1111, 4'b1111, 16'hFFFF);
            sb.push_back('{tag: "reset", cyc: c, v: ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0)});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
        sb.push_back('{tag: "reset_release", cyc: 3, v: ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0)});
        tick();
        ex = sb.pop_front();
        n_cmp++;
        if (obs() !== ex.v) begin
            n_err++;
            $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
        end
    endtask

    // Each enable lasts 6 cycles (ack 5 after it appears), then GAP, then SELECT: period 8
    task automatic test_full_sequence();
        exp_t ex;
        int k, ph, n;
        logic [3:0] ack, en_e;
        i_skip_mask = 4'b0000;
        for (int c = 0; c <= 34; c++) begin
            ack = 4'b0000;
            if (c >= 1 && c <= 32 && ((c - 1) % 8) == 6) ack = 4'b0001 << ((c - 1) / 8);
            drive(1'b1, 1'b0, ack, 4'b0000, 16'h0000);
            n = c + 1;
            if (n <= 32) begin
                k  = (n - 1) / 8;
                ph = (n - 1) % 8;
                en_e = (ph >= 1 && ph <= 6) ? (4'b0001 << k) : 4'b0000;
                sb.push_back('{tag: "full_seq", cyc: n, v: ev(en_e, 2'(k), 1'b0, 1'b0, 1'b0, 4'h0)});
            end else begin
                sb.push_back('{tag: "full_done", cyc: n, v: ev(4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0)});
            end
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
        sb.push_back('{tag: "full_exit", cyc: 36, v: ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0)});
        tick();
        ex = sb.pop_front();
        n_cmp++;
        if (obs() !== ex.v) begin
            n_err++;
            $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
        end
    endtask

    task automatic test_skip_sparse();
        exp_t ex;
        logic [3:0] seen, ack;
        logic done_seen;
        int run;
        seen = 4'b0000;
        done_seen = 1'b0;
        run = 0;
        i_skip_mask = 4'b0101;
        sb.push_back('{tag: "skip0101_enables", cyc: 0, v: 13'(4'b1010)});
        sb.push_back('{tag: "skip0101_done", cyc: 0, v: 13'(1)});
        for (int c = 0; c < 80 && !done_seen; c++) begin
            ack = 4'b0000;
            if (o_substate_en != 4'b0000) begin
                run++;
                if (run == 6) ack = o_substate_en;
            end else begin
                run = 0;
            end
            drive(1'b1, 1'b0, ack, 4'b0000, 16'h0000);
            tick();
            seen |= o_substate_en;
            if (o_done) done_seen = 1'b1;
        end
        ex = sb.pop_front();
        n_cmp++;
        if (13'(seen) !== ex.v) begin
            n_err++;
            $display("FAIL %s: got enables seen %b required %b", ex.tag, seen, ex.v[3:0]);
        end
        ex = sb.pop_front();
        n_cmp++;
        if (13'(done_seen) !== ex.v) begin
            n_err++;
            $display("FAIL %s: got done %b required %b within 80 cycles", ex.tag, done_seen, ex.v[0]);
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
        tick();
    endtask

    task automatic test_skip_all();
        exp_t ex;
        i_skip_mask = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 4'b0000, 4'b0000, 16'h0000);
            if (c < 4) sb.push_back('{tag: "skip_all_select", cyc: c + 1, v: ev(4'b0000, 2'(c), 1'b0, 1'b0, 1'b0, 4'h0)});
            else       sb.push_back('{tag: "skip_all_done", cyc: c + 1, v: ev(4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0)});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
        sb.push_back('{tag: "skip_all_exit", cyc: 6, v: ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0)});
        tick();
        ex = sb.pop_front();
        n_cmp++;
        if (obs() !== ex.v) begin
            n_err++;
            $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
        end
    endtask

    task automatic test_msg_mux();
        exp_t ex;
        logic        t_en  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  t_vld [5] = '{4'b0101, 4'b0001, 4'b0110, 4'b1011, 4'b0100};
        logic [15:0] t_msg [5] = '{16'h0A05, 16'h0A05, 16'h03F0, 16'h9A05, 16'h0A00};
        logic [12:0] t_exp [5];
        t_exp[0] = ev(4'b0100, 2'd2, 1'b0, 1'b0, 1'b1, 4'hA);
        t_exp[1] = ev(4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0);
        t_exp[2] = ev(4'b0100, 2'd2, 1'b0, 1'b0, 1'b1, 4'h3);
        t_exp[3] = ev(4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0);
        t_exp[4] = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        i_skip_mask = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 4'b0000, 4'b0000, 16'h0000);
            if (c < 3) sb.push_back('{tag: "mux_select", cyc: c + 1, v: ev(4'b0000, 2'(c), 1'b0, 1'b0, 1'b0, 4'h0)});
            else       sb.push_back('{tag: "mux_run_entry", cyc: c + 1, v: ev(4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0)});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        for (int s = 0; s < 5; s++) begin
            drive(t_en[s], 1'b0, 4'b0000, t_vld[s], t_msg[s]);
            sb.push_back('{tag: "mux_select_gate", cyc: s, v: t_exp[s]});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s step %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
    endtask

    task automatic test_abort();
        exp_t ex;
        logic        t_en  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  t_ack [10] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [3:0]  t_vld [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
        logic [3:0]  t_een [10] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0};
        logic [1:0]  t_idx [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        logic        t_ev  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        i_skip_mask = 4'b0000;
        for (int s = 0; s < 10; s++) begin
            drive(t_en[s], 1'b0, t_ack[s], t_vld[s], 16'h0070);
            sb.push_back('{tag: "abort", cyc: s + 1,
                           v: ev(t_een[s], t_idx[s], 1'b0, 1'b0, t_ev[s], t_ev[s] ? 4'h7 : 4'h0)});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
    endtask

    task automatic test_stray_ack();
        exp_t ex;
        logic        t_en  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  t_ack [12] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h8, 4'h9, 4'h8, 4'h2, 4'h0, 4'h0, 4'h0};
        logic [3:0]  t_een [12] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0};
        logic [1:0]  t_idx [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        i_skip_mask = 4'b0000;
        for (int s = 0; s < 12; s++) begin
            drive(t_en[s], 1'b0, t_ack[s], 4'b0000, 16'h0000);
            sb.push_back('{tag: "stray_ack", cyc: s + 1, v: ev(t_een[s], t_idx[s], 1'b0, 1'b0, 1'b0, 4'h0)});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
    endtask

`ifdef MBTRAIN_SEQ_TIMEOUT_EN
    // RUN entered at cycle 2; count hits 15 at cycle 17, so the error shows at cycle 18
    task automatic test_timeout_expiry();
        exp_t ex;
        logic [12:0] e;
        i_skip_mask = 4'b0000;
        for (int c = 0; c <= 20; c++) begin
            drive(1'b1, (c == 20), 4'b0000, 4'b0000, 16'h0000);
            if (c == 0)       e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
            else if (c <= 16) e = ev(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
            else if (c <= 19) e = ev(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 4'h0);
            else              e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
            sb.push_back('{tag: "timeout_expiry", cyc: c + 1, v: e});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
        tick();
    endtask

    task automatic test_timeout_ack_wins();
        exp_t ex;
        logic [12:0] e;
        i_skip_mask = 4'b0000;
        for (int c = 0; c <= 19; c++) begin
            drive(1'b1, 1'b0, (c == 17) ? 4'b0001 : 4'b0000, 4'b0000, 16'h0000);
            if (c == 0)       e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
            else if (c <= 16) e = ev(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
            else if (c == 17) e = ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
            else if (c == 18) e = ev(4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0);
            else              e = ev(4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0);
            sb.push_back('{tag: "timeout_ack_wins", cyc: c + 1, v: e});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
        tick();
    endtask
`else
    task automatic test_no_timeout();
        exp_t ex;
        i_skip_mask = 4'b0000;
        for (int c = 0; c <= 40; c++) begin
            drive(1'b1, 1'b0, 4'b0000, 4'b0000, 16'h0000);
            if (c == 0) sb.push_back('{tag: "no_timeout", cyc: 1, v: ev(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0)});
            else        sb.push_back('{tag: "no_timeout", cyc: c + 1, v: ev(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0)});
            tick();
            ex = sb.pop_front();
            n_cmp++;
            if (obs() !== ex.v) begin
                n_err++;
                $display("FAIL %s cyc %0d: got {en,idx,done,err,vld,msg}=%b required %b", ex.tag, ex.cyc, obs(), ex.v);
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000);
        tick();
    endtask
`endif

    initial begin
        i_skip_mask = 4'b0000;
        drive(1'b0, 1'b1, 4'b0000, 4'b0000, 16'h0000);
        test_reset();
        test_full_sequence();
        test_skip_sparse();
        test_skip_all();
        test_msg_mux();
        test_abort();
        test_stray_ack();
`ifdef MBTRAIN_SEQ_TIMEOUT_EN
        test_timeout_expiry();
        test_timeout_ack_wins();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mbtrain_substate_sequencer.md
Name: mbtrain_substate_sequencer

Overview:
- Sequences the MBTRAIN substate wrappers: self-cal, vref, clock-cal, center-cal and similar.
- Enables one substate at a time, in index order, and waits for that substate's test_ack.
- Muxes the active substate's sideband message and valid onto the shared LTSM sideband encoder path.
- Sits between the LTSM top FSM (MBTRAIN entry enable) and the N substate wrappers; raises done or a timeout error back to the LTSM.

Parameters:
- NUM_SUBSTATES, 8, number of sequenced substates (2..16).
- MSG_W, 4, width of the decoded/encoded sideband message code.
- TIMEOUT_CYCLES, 4096, maximum cycles a substate may stay enabled without ack (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_en  in  1  MBTRAIN entry enable from LTSM; level-sensitive.
- i_skip_mask  in  NUM_SUBSTATES  bit k=1: substate k is bypassed; sampled in SELECT.
- i_substate_ack  in  NUM_SUBSTATES  per-substate test_ack.
- i_substate_valid  in  NUM_SUBSTATES  per-substate sideband valid.
- i_substate_msg  in  NUM_SUBSTATES*MSG_W  flattened messages; substate k occupies bits [k*MSG_W +: MSG_W].
- o_substate_en  out  NUM_SUBSTATES  one-hot enable to the substates.
- o_sideband_message  out  MSG_W  registered message of the active substate.
- o_valid  out  1  registered valid of the active substate.
- o_current_idx  out  clog2(NUM_SUBSTATES)  index being serviced.
- o_done  out  1  all non-skipped substates acked.
- o_timeout_err  out  1  substate timed out (optional feature only).

Behaviour:
- Single clock domain; rst is synchronous, active-high, and is the highest-priority condition.
- Reset values: all outputs 0; state IDLE; idx 0; timeout counter 0.
- States: IDLE, SELECT, RUN, GAP, DONE, ERROR.
- IDLE: when i_en=1, go to SELECT with idx=0.
- SELECT:
  - skip_mask[idx]=1: if idx is last, go to DONE; else idx+1 and stay in SELECT (one cycle per skipped substate).
  - Otherwise: assert o_substate_en[idx] (registered, visible next cycle) and go to RUN; timeout counter cleared.
- RUN:
  - o_substate_en stays one-hot at idx.
  - i_substate_ack[idx]=1: deassert enable and go to GAP.
  - Acks on any other index are ignored.
- GAP: exactly one cycle with all enables 0, so each substate returns to its own idle. Then go to DONE if idx is last; else idx+1 and go to SELECT.
- DONE: o_done=1; stays until i_en=0, then returns to IDLE (o_done clears the cycle IDLE is entered).
- i_en=0 in any state: next cycle state is IDLE, all enables 0, o_valid 0, idx 0, flags cleared.
- Sideband mux:
  - In RUN: o_valid <= i_substate_valid[idx]; o_sideband_message <= msg slice[idx] when that valid=1, else 0.
  - Outside RUN: both register 0.
  - Latency: one cycle. Valid from non-active substates is never forwarded.
- o_current_idx is the idx register directly.
- Minimum sequence length, no skips: 1 (SELECT) + RUN duration + 1 (GAP) per substate, plus 1 cycle into DONE.

Optional Feature:
- Macro: MBTRAIN_SEQ_TIMEOUT_EN.
- With the macro:
  - In RUN, the counter increments each cycle without ack.
  - When count reaches TIMEOUT_CYCLES-1 with no ack, go to ERROR: enables 0, o_timeout_err=1, held until i_en=0.
  - Ack in the same cycle as expiry: ack wins, go to GAP.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Without the macro: no counter and no ERROR state; o_timeout_err tied 0; RUN waits indefinitely.

Decomposition:
- Shared package mbtrain_pkg holds:
  - state enum (IDLE..ERROR);
  - MSG_W default;
  - substate index constants (SELFCAL_IDX, VALVREF_IDX, ...).
- One sub-module, mbtrain_msg_mux: registered indexed MSG_W/valid select with gating. It is reusable by other LTSM wrappers in place of per-wrapper 4:1 muxes.

Test Plan:
- Full sequence, NUM_SUBSTATES=4, no skips, each ack 5 cycles after its enable:
  - en pulses one-hot 0,1,2,3, each separated by exactly one all-zero GAP cycle;
  - o_done=1 one cycle after the last GAP.
- Skip handling, skip_mask=4'b0101: only en[1] and en[3] ever assert. skip_mask=4'b1111: o_done after 4 SELECT cycles plus 1, with no enable ever asserted.
- Message mux: in RUN idx=2, substate 2 drives msg=4'hA valid=1 while substate 0 drives 4'h5 valid=1 → next cycle o_sideband_message=4'hA, o_valid=1. Substate 2 valid=0 → outputs 0.
- Abort: drop i_en mid-RUN at idx=1 → next cycle enables 0, o_valid 0, idx 0, state IDLE. Reassert i_en → sequence restarts at idx 0.
- Stray ack: assert ack[3] while in RUN at idx=1 → no state change; correct ack[1] → GAP.
- Timeout (MBTRAIN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - no ack → o_timeout_err=1 exactly 16 cycles after RUN entry, enables 0;
  - ack on cycle 16 → GAP, no error;
  - rst asserted in ERROR → all outputs 0 the next cycle.
